alu_issue: RTL

Decode-and-issue stage that sits directly upstream of the execute-stage ALU. It accepts one RV32I register-register (OP) or register-immediate (OP-IMM) instruction per cycle, together with its read register values, over a valid/ready handshake. It produces the ALU's 4-bit operation select, operand A, operand B and destination register through a registered, full-throughput 2-entry skid buffer.

---
 rtl/alu_issue.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM decode-and-issue stage with 2-entry skid buffer; optional LUI decode via ALU_ISSUE_LUI_EN
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_sel,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_AND  = 4'b0010;
  localparam logic [3:0] SEL_OR   = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_SLL  = 4'b0101;
  localparam logic [3:0] SEL_SRL  = 4'b0110;
  localparam logic [3:0] SEL_SRA  = 4'b0111;
  localparam logic [3:0] SEL_SLT  = 4'b1001;
  localparam logic [3:0] SEL_SLTU = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
`ifdef ALU_ISSUE_LUI_EN
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
`endif

  typedef struct packed {
    logic [3:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            f7_zero;
  logic            f7_alt;
  logic            ok;
  logic [3:0]      sel_v;
  logic [XLEN-1:0] a_v;
  logic [XLEN-1:0] b_v;
  entry_t          dec;

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   in_fire;
  logic   out_fire;

  // rs1 field is consumed as a register value upstream, not as raw bits here
  logic unused_rs1_field;
  assign unused_rs1_field = ^in_instr[19:15];

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // decode the incoming instruction into ALU select and operands
  always_comb begin
    sel_v = SEL_ADD;
    a_v   = '0;
    b_v   = '0;
    ok    = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_v = in_rs1;
        b_v = in_rs2;
        case (funct3)
          3'b000: begin ok = f7_zero | f7_alt; sel_v = f7_alt ? SEL_SUB : SEL_ADD; end
          3'b001: begin ok = f7_zero; sel_v = SEL_SLL;  end
          3'b010: begin ok = f7_zero; sel_v = SEL_SLT;  end
          3'b011: begin ok = f7_zero; sel_v = SEL_SLTU; end
          3'b100: begin ok = f7_zero; sel_v = SEL_XOR;  end
          3'b101: begin ok = f7_zero | f7_alt; sel_v = f7_alt ? SEL_SRA : SEL_SRL; end
          3'b110: begin ok = f7_zero; sel_v = SEL_OR;   end
          default: begin ok = f7_zero; sel_v = SEL_AND; end
        endcase
      end
      OPC_OP_IMM: begin
        a_v = in_rs1;
        b_v = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        case (funct3)
          3'b000: begin ok = 1'b1; sel_v = SEL_ADD;  end
          3'b001: begin
            ok    = f7_zero;
            sel_v = SEL_SLL;
            b_v   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          end
          3'b010: begin ok = 1'b1; sel_v = SEL_SLT;  end
          3'b011: begin ok = 1'b1; sel_v = SEL_SLTU; end
          3'b100: begin ok = 1'b1; sel_v = SEL_XOR;  end
          3'b101: begin
            ok    = f7_zero | f7_alt;
            sel_v = f7_alt ? SEL_SRA : SEL_SRL;
            b_v   = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          end
          3'b110: begin ok = 1'b1; sel_v = SEL_OR;   end
          default: begin ok = 1'b1; sel_v = SEL_AND; end
        endcase
      end
`ifdef ALU_ISSUE_LUI_EN
      OPC_LUI: begin
        // ALU computes 0 + upper immediate
        ok    = 1'b1;
        sel_v = SEL_ADD;
        a_v   = '0;
        b_v   = {in_instr[31:12], 12'b0};
      end
`endif
      default: ok = 1'b0;
    endcase
  end

  // illegal encodings are squashed to a harmless ADD 0,0 but keep rd
  always_comb begin
    dec     = '0;
    dec.rd  = in_instr[11:7];
    dec.ill = ~ok;
    if (ok) begin
      dec.sel = sel_v;
      dec.a   = a_v;
      dec.b   = b_v;
    end
  end

  assign in_fire  = in_valid & ~skid_valid;
  assign out_fire = main_valid & out_ready;

  // main/skid buffer: main drives outputs, skid absorbs one entry during a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q <= dec;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready    = ~skid_valid;
  assign out_valid   = main_valid;
  assign out_sel     = main_q.sel;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.ill;

endmodule
